// File: rtl/pci_pkg.sv
// Shared PCI target definitions: bus command encodings, target FSM states, command decode helpers.
package pci_pkg;

  localparam logic [3:0] CMD_IO_RD  = 4'b0010;
  localparam logic [3:0] CMD_IO_WR  = 4'b0011;
  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IGNORE,
    ST_TURN,
    ST_WAIT,
    ST_DATA,
    ST_DISC,
    ST_RELEASE
  } state_t;

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == CMD_IO_RD) || (cmd == CMD_IO_WR) ||
           (cmd == CMD_MEM_RD) || (cmd == CMD_MEM_WR);
  endfunction

  function automatic logic cmd_is_read(input logic [3:0] cmd);
    return (cmd == CMD_IO_RD) || (cmd == CMD_MEM_RD);
  endfunction

endpackage

// File: rtl/pci_target_mem.sv
// Target backing store, 2^ADDR_BITS x 32: byte-lane write on the rising edge, combinational read.
// Deliberately has no reset so contents survive a target reset.
module pci_target_mem #(
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [3:0]           wr_be,
  input  logic [31:0]          wr_dat,
  input  logic [ADDR_BITS-1:0] idx,
  output logic [31:0]          rd_dat
);

  logic [31:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end

  assign rd_dat = mem[idx];

endmodule

// File: rtl/pci_target_burst.sv
// PCI target with a linear-burst memory window; DEVSEL one cycle after the address edge, then WAIT_STATES waits.
// IRDY high stalls a data phase; hitting the last word with FRAME still low disconnects via STOP.
module pci_target_burst
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          ADDR_BITS   = 6,
  parameter int          WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RST,
  inout  wire  [31:0] AD,
  input  logic [3:0]  CBE,
  input  logic        FRAME,
  input  logic        IRDY,
  output wire         TRDY,
  output wire         DEVSEL,
  output wire         STOP
);

  localparam logic [ADDR_BITS-1:0] LAST_IDX   = '1;
  localparam logic [3:0]           WS         = 4'(WAIT_STATES);
  localparam state_t               FIRST_DATA = (WAIT_STATES != 0) ? ST_WAIT : ST_DATA;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] idx, idx_nxt;
  logic [3:0]           wcnt, wcnt_nxt;
  logic                 is_rd, is_rd_nxt;
  logic                 armed, armed_nxt;
  logic                 hit, xfer, mem_we;
  logic                 ctl_oe, ad_oe;
  logic                 trdy_drv, devsel_drv, stop_drv;
  logic [31:0]          rd_dat;
  logic                 unused_ad;

  assign hit       = cmd_supported(CBE) && (AD[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign xfer      = (state == ST_DATA) && !IRDY;
  assign mem_we    = xfer && !is_rd && RST;
  assign unused_ad = ^AD[1:0];

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    wcnt_nxt   = wcnt;
    is_rd_nxt  = is_rd;
    // A transaction caught mid-flight after reset is ignored until the bus goes idle.
    armed_nxt  = armed | (FRAME & IRDY);
    ctl_oe     = 1'b0;
    ad_oe      = 1'b0;
    trdy_drv   = 1'b1;
    devsel_drv = 1'b1;
    stop_drv   = 1'b1;
    case (state)
      ST_IDLE: begin
        if (armed && !FRAME) begin
          if (hit) begin
            idx_nxt   = AD[ADDR_BITS+1:2];
            wcnt_nxt  = WS;
            is_rd_nxt = cmd_is_read(CBE);
            state_nxt = cmd_is_read(CBE) ? ST_TURN : FIRST_DATA;
          end else begin
            state_nxt = ST_IGNORE;
          end
        end
      end
      ST_IGNORE: begin
        if (FRAME && IRDY) state_nxt = ST_IDLE;
      end
      ST_TURN: begin
        ctl_oe     = 1'b1;
        devsel_drv = 1'b0;
        state_nxt  = FIRST_DATA;
      end
      ST_WAIT: begin
        ctl_oe     = 1'b1;
        devsel_drv = 1'b0;
        ad_oe      = is_rd;
        wcnt_nxt   = wcnt - 4'd1;
        if (wcnt <= 4'd1) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        ctl_oe     = 1'b1;
        devsel_drv = 1'b0;
        trdy_drv   = 1'b0;
        ad_oe      = is_rd;
        if (!IRDY) begin
          // Saturate at the top word: the burst disconnects rather than wrapping.
          if (idx != LAST_IDX) idx_nxt = idx + 1'b1;
          if (FRAME)                 state_nxt = ST_RELEASE;
          else if (idx == LAST_IDX)  state_nxt = ST_DISC;
        end
      end
      ST_DISC: begin
        ctl_oe     = 1'b1;
        devsel_drv = 1'b0;
        stop_drv   = 1'b0;
        ad_oe      = is_rd;
        if (FRAME) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        ctl_oe    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= ST_IDLE;
      idx   <= '0;
      wcnt  <= '0;
      is_rd <= 1'b0;
      armed <= FRAME & IRDY;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      wcnt  <= wcnt_nxt;
      is_rd <= is_rd_nxt;
      armed <= armed_nxt;
    end
  end

  pci_target_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk    (CLK),
    .wr_en  (mem_we),
    .wr_be  (~CBE),
    .wr_dat (AD),
    .idx    (idx),
    .rd_dat (rd_dat)
  );

  assign AD     = ad_oe  ? rd_dat     : 32'bz;
  assign TRDY   = ctl_oe ? trdy_drv   : 1'bz;
  assign DEVSEL = ctl_oe ? devsel_drv : 1'bz;
  assign STOP   = ctl_oe ? stop_drv   : 1'bz;

endmodule

// File: tb/tb_pci_target_burst.sv
// Directed bench for pci_target_burst: master tasks run PCI cycles, tests compare bus values to hand-derived ones.
// Control lines carry pullups as on a real PCI bus, so a released line reads 1.
module tb_pci_target_burst;

  logic        CLK   = 1'b0;
  logic        RST   = 1'b0;
  logic [3:0]  CBE   = 4'hF;
  logic        FRAME = 1'b1;
  logic        IRDY  = 1'b1;
  logic [31:0] m_ad  = '0;
  logic        m_oe  = 1'b0;
  wire  [31:0] AD;
  wire         TRDY;
  wire         DEVSEL;
  wire         STOP;

  int          n_run  = 0;
  int          n_fail = 0;
  logic [31:0] bdat [4];
  logic [3:0]  bbe  [4];
  logic [31:0] rdat [4];
  logic        addr_dev, addr_trdy, disc_ok;
  logic [31:0] wait_ad;

  assign AD = m_oe ? m_ad : 32'bz;
  pullup (TRDY);
  pullup (DEVSEL);
  pullup (STOP);

  always #5 CLK = ~CLK;

  pci_target_burst #(
    .BASE_ADDR   (32'h0000_1000),
    .ADDR_BITS   (6),
    .WAIT_STATES (2)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .AD     (AD),
    .CBE    (CBE),
    .FRAME  (FRAME),
    .IRDY   (IRDY),
    .TRDY   (TRDY),
    .DEVSEL (DEVSEL),
    .STOP   (STOP)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    FRAME = 1'b1; IRDY = 1'b1; m_oe = 1'b0; CBE = 4'hF;
    tick();
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd);
    FRAME = 1'b0; IRDY = 1'b1; m_ad = a; m_oe = 1'b1; CBE = cmd;
    tick();
    addr_dev  = DEVSEL;
    addr_trdy = TRDY;
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [3:0] cmd, input int n,
                             output int lat, output int done, output logic stopped);
    int guard;
    addr_phase(a, cmd);
    lat = 0; done = 0; stopped = 1'b0; disc_ok = 1'b0;
    for (int k = 0; k < n; k++) begin
      m_ad = bdat[k]; CBE = bbe[k]; IRDY = 1'b0; FRAME = (k == n - 1);
      guard = 0;
      while (TRDY !== 1'b0 && STOP !== 1'b0 && guard < 20) begin tick(); guard++; end
      if (k == 0) lat = guard;
      if (STOP === 1'b0) begin
        stopped = 1'b1;
        disc_ok = (DEVSEL === 1'b0) && (TRDY === 1'b1);
        break;
      end
      if (guard >= 20) break;
      tick();
      done++;
    end
    if (stopped) begin FRAME = 1'b1; tick(); end
  endtask

  task automatic read_burst(input logic [31:0] a, input logic [3:0] cmd, input int n, output int lat);
    int guard;
    addr_phase(a, cmd);
    m_oe = 1'b0; IRDY = 1'b0; lat = 0; wait_ad = '0;
    for (int k = 0; k < n; k++) begin
      FRAME = (k == n - 1);
      guard = 0;
      while (TRDY !== 1'b0 && guard < 20) begin
        tick(); guard++;
        if (guard == 1) wait_ad = AD;
      end
      if (k == 0) lat = guard;
      rdat[k] = AD;
      if (guard >= 20) break;
      tick();
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick(); tick();
    n_run++; if (TRDY !== 1'b1)   begin n_fail++; $display("FAIL reset_trdy: got %b expected 1", TRDY); end
    n_run++; if (DEVSEL !== 1'b1) begin n_fail++; $display("FAIL reset_devsel: got %b expected 1", DEVSEL); end
    n_run++; if (STOP !== 1'b1)   begin n_fail++; $display("FAIL reset_stop: got %b expected 1", STOP); end
    FRAME = 1'b0; m_ad = 32'h0000_1004; m_oe = 1'b1; CBE = 4'b0111;
    tick();
    n_run++; if (DEVSEL !== 1'b1) begin n_fail++; $display("FAIL reset_blocks_decode: got %b expected 1", DEVSEL); end
    FRAME = 1'b1; m_oe = 1'b0; CBE = 4'hF;
    tick();
    RST = 1'b1;
    bus_idle();
  endtask

  task automatic test_single_write();
    int lat, done; logic stp;
    bdat[0] = 32'hDEAD_BEEF; bbe[0] = 4'b0000;
    write_burst(32'h0000_1004, 4'b0111, 1, lat, done, stp);
    n_run++; if (addr_dev !== 1'b0) begin n_fail++; $display("FAIL wr_devsel_after_addr: got %b expected 0", addr_dev); end
    n_run++; if (lat !== 2)         begin n_fail++; $display("FAIL wr_wait_cycles: got %0d expected 2", lat); end
    n_run++; if (done !== 1)        begin n_fail++; $display("FAIL wr_beats: got %0d expected 1", done); end
    n_run++; if (DEVSEL !== 1'b1 || TRDY !== 1'b1 || STOP !== 1'b1)
      begin n_fail++; $display("FAIL wr_release: got devsel=%b trdy=%b stop=%b expected 1 1 1", DEVSEL, TRDY, STOP); end
    bus_idle();
    n_run++; if (DEVSEL !== 1'b1) begin n_fail++; $display("FAIL wr_idle_devsel: got %b expected 1", DEVSEL); end
  endtask

  task automatic test_read_after_write();
    int lat;
    read_burst(32'h0000_1004, 4'b0010, 1, lat);
    n_run++; if (addr_dev !== 1'b0)  begin n_fail++; $display("FAIL rd_turn_devsel: got %b expected 0", addr_dev); end
    n_run++; if (addr_trdy !== 1'b1) begin n_fail++; $display("FAIL rd_turn_trdy: got %b expected 1", addr_trdy); end
    n_run++; if (lat !== 3)          begin n_fail++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    n_run++; if (wait_ad !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_wait_ad: got %h expected deadbeef", wait_ad); end
    n_run++; if (rdat[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", rdat[0]); end
    bus_idle();
  endtask

  task automatic test_byte_enable();
    int lat, done; logic stp;
    bdat[0] = 32'h1122_3344; bbe[0] = 4'b1100;
    write_burst(32'h0000_1004, 4'b0111, 1, lat, done, stp);
    bus_idle();
    read_burst(32'h0000_1004, 4'b0110, 1, lat);
    n_run++; if (rdat[0] !== 32'hDEAD_3344) begin n_fail++; $display("FAIL be_merge: got %h expected dead3344", rdat[0]); end
    bus_idle();
  endtask

  task automatic test_burst_end();
    int lat, done; logic stp;
    bdat[0] = 32'hA5A5_5A5A; bbe[0] = 4'b0000;
    write_burst(32'h0000_1000, 4'b0111, 1, lat, done, stp);
    bus_idle();
    for (int k = 0; k < 4; k++) begin bdat[k] = 32'hC0DE_0062 + k; bbe[k] = 4'b0000; end
    write_burst(32'h0000_10F8, 4'b0111, 4, lat, done, stp);
    n_run++; if (stp !== 1'b1)     begin n_fail++; $display("FAIL end_stop_seen: got %b expected 1", stp); end
    n_run++; if (done !== 2)       begin n_fail++; $display("FAIL end_beats: got %0d expected 2", done); end
    n_run++; if (disc_ok !== 1'b1) begin n_fail++; $display("FAIL end_disc_outputs: got %b expected 1", disc_ok); end
    bus_idle();
    read_burst(32'h0000_10F8, 4'b0110, 2, lat);
    n_run++; if (rdat[0] !== 32'hC0DE_0062) begin n_fail++; $display("FAIL end_word62: got %h expected c0de0062", rdat[0]); end
    n_run++; if (rdat[1] !== 32'hC0DE_0063) begin n_fail++; $display("FAIL end_word63: got %h expected c0de0063", rdat[1]); end
    bus_idle();
    read_burst(32'h0000_1000, 4'b0110, 1, lat);
    n_run++; if (rdat[0] !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL end_no_wrap: got %h expected a5a55a5a", rdat[0]); end
    bus_idle();
  endtask

  task automatic test_null_be();
    int lat, done; logic stp;
    bdat[0] = 32'hFFFF_FFFF; bbe[0] = 4'b1111;
    bdat[1] = 32'h1234_5678; bbe[1] = 4'b0000;
    write_burst(32'h0000_1004, 4'b0111, 2, lat, done, stp);
    n_run++; if (done !== 2) begin n_fail++; $display("FAIL nullbe_beats: got %0d expected 2", done); end
    bus_idle();
    read_burst(32'h0000_1004, 4'b0110, 2, lat);
    n_run++; if (rdat[0] !== 32'hDEAD_3344) begin n_fail++; $display("FAIL nullbe_word1: got %h expected dead3344", rdat[0]); end
    n_run++; if (rdat[1] !== 32'h1234_5678) begin n_fail++; $display("FAIL nullbe_word2: got %h expected 12345678", rdat[1]); end
    bus_idle();
  endtask

  task automatic test_miss_stall();
    logic seen_low, bad;
    int   guard, lat;
    addr_phase(32'h0000_2000, 4'b0111);
    m_ad = 32'hBAD0_BAD0; CBE = 4'b0000; IRDY = 1'b0; FRAME = 1'b1;
    seen_low = (DEVSEL !== 1'b1);
    for (int i = 0; i < 4; i++) begin tick(); if (DEVSEL !== 1'b1 || TRDY !== 1'b1) seen_low = 1'b1; end
    n_run++; if (seen_low !== 1'b0) begin n_fail++; $display("FAIL miss_addr_selected: got %b expected 0", seen_low); end
    bus_idle();
    addr_phase(32'h0000_1004, 4'b1111);
    m_ad = 32'hBAD0_BAD0; CBE = 4'b0000; IRDY = 1'b0; FRAME = 1'b1;
    seen_low = (DEVSEL !== 1'b1);
    for (int i = 0; i < 4; i++) begin tick(); if (DEVSEL !== 1'b1 || TRDY !== 1'b1) seen_low = 1'b1; end
    n_run++; if (seen_low !== 1'b0) begin n_fail++; $display("FAIL miss_cmd_selected: got %b expected 0", seen_low); end
    bus_idle();
    addr_phase(32'h0000_1004, 4'b0110);
    m_oe = 1'b0; IRDY = 1'b1; FRAME = 1'b0;
    guard = 0;
    while (TRDY !== 1'b0 && guard < 20) begin tick(); guard++; end
    n_run++; if (guard !== 3) begin n_fail++; $display("FAIL stall_latency: got %0d expected 3", guard); end
    bad = (AD !== 32'hDEAD_3344);
    for (int i = 0; i < 3; i++) begin tick(); if (AD !== 32'hDEAD_3344 || TRDY !== 1'b0) bad = 1'b1; end
    n_run++; if (bad !== 1'b0) begin n_fail++; $display("FAIL stall_ad_frozen: got ad=%h trdy=%b expected dead3344 0", AD, TRDY); end
    IRDY = 1'b0;
    tick();
    n_run++; if (AD !== 32'h1234_5678) begin n_fail++; $display("FAIL stall_resume_ad: got %h expected 12345678", AD); end
    FRAME = 1'b1;
    tick();
    n_run++; if (DEVSEL !== 1'b1 || TRDY !== 1'b1) begin n_fail++; $display("FAIL stall_release: got devsel=%b trdy=%b expected 1 1", DEVSEL, TRDY); end
    bus_idle();
  endtask

  task automatic test_reset_mid_burst();
    logic seen_low;
    int   guard, lat;
    addr_phase(32'h0000_1010, 4'b0111);
    m_ad = 32'h4444_4444; CBE = 4'b0000; IRDY = 1'b0; FRAME = 1'b0;
    guard = 0;
    while (TRDY !== 1'b0 && guard < 20) begin tick(); guard++; end
    tick();
    n_run++; if (TRDY !== 1'b0) begin n_fail++; $display("FAIL rst_pre_data: got %b expected 0", TRDY); end
    m_ad = 32'h5555_5555; RST = 1'b0;
    tick();
    n_run++; if (TRDY !== 1'b1 || DEVSEL !== 1'b1 || STOP !== 1'b1)
      begin n_fail++; $display("FAIL rst_mid_release: got trdy=%b devsel=%b stop=%b expected 1 1 1", TRDY, DEVSEL, STOP); end
    RST = 1'b1; m_ad = 32'h0000_1014; CBE = 4'b0111;
    seen_low = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (DEVSEL !== 1'b1) seen_low = 1'b1; end
    n_run++; if (seen_low !== 1'b0) begin n_fail++; $display("FAIL rst_inflight_ignored: got %b expected 0", seen_low); end
    bus_idle();
    read_burst(32'h0000_1010, 4'b0110, 1, lat);
    n_run++; if (lat !== 3) begin n_fail++; $display("FAIL rst_next_latency: got %0d expected 3", lat); end
    n_run++; if (rdat[0] !== 32'h4444_4444) begin n_fail++; $display("FAIL rst_next_data: got %h expected 44444444", rdat[0]); end
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_after_write();
    test_byte_enable();
    test_burst_end();
    test_null_be();
    test_miss_stall();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pci_target_burst.md
PCI_TARGET_BURST -- requirements
Module: pci_target_burst

Interface
REQ-001 Parameters SHALL be:
- BASE_ADDR, 32'h0000_1000, byte base address of the decoded window, aligned to its size.
- ADDR_BITS, 6, word-address width; memory depth 2^ADDR_BITS x 32 bits.
- WAIT_STATES, 0, initial target wait states per transaction (0..13).
REQ-002 Ports SHALL be:
- CLK     input   1   single clock; all logic on its rising edge.
- RST     input   1   synchronous reset, active low.
- AD      inout   32  multiplexed address/data bus.
- CBE     input   4   command (address phase) or active-low byte enables (data phase).
- FRAME   input   1   active-low transaction frame, driven by the master.
- IRDY    input   1   active-low initiator ready.
- TRDY    output  1   active-low target ready; high-Z when not selected.
- DEVSEL  output  1   active-low device select; high-Z when not selected.
- STOP    output  1   active-low disconnect request; high-Z when not selected.

Function
REQ-003 Supported commands SHALL be 0010 I/O read, 0011 I/O write, 0110 memory read, 0111 memory write; all other commands are ignored.
REQ-004 An address phase SHALL be detected in IDLE on a rising edge with FRAME=0; AD and CBE are latched on that edge.
REQ-005 A hit SHALL require a supported command and AD[31:ADDR_BITS+2]==BASE_ADDR[31:ADDR_BITS+2]; the word index is AD[ADDR_BITS+1:2].
REQ-006 On a miss, the FSM SHALL enter IGNORE, keep all outputs high-Z, and return to IDLE on the first edge with FRAME=1 and IRDY=1.
REQ-007 FSM states SHALL be IDLE, IGNORE, TURN, WAIT, DATA, DISC and RELEASE.
REQ-008 On a read hit, DEVSEL SHALL go low in the cycle after the address edge (TURN, with AD high-Z and TRDY=1).
REQ-009 On a write hit, DEVSEL SHALL go low in the cycle after the address edge, and the FSM SHALL go directly to WAIT or DATA.
REQ-010 WAIT SHALL hold TRDY=1 for exactly WAIT_STATES cycles using a down-counter; WAIT is skipped when WAIT_STATES=0.
REQ-011 In DATA, TRDY SHALL be 0; a transfer completes on each edge where IRDY=0 and TRDY=0.
REQ-012 During a read, AD SHALL carry mem[index] from the cycle after TURN until RELEASE.
REQ-013 During a write, on each completed transfer, byte lane i SHALL be written only when CBE[i]=0.
REQ-014 After each completed transfer, the word index SHALL increment by 1 (linear burst).
REQ-015 If a transfer completes with FRAME=1 (final data phase), the FSM SHALL go to RELEASE.
REQ-016 If a transfer completes at index 2^ADDR_BITS-1 with FRAME=0, the FSM SHALL go to DISC; it SHALL never wrap.
REQ-017 DISC SHALL drive STOP=0, TRDY=1 and DEVSEL=0 until an edge samples FRAME=1, then go to RELEASE.
REQ-018 RELEASE SHALL last one cycle, driving TRDY=1, DEVSEL=1 and STOP=1 with AD high-Z; all outputs then go high-Z in IDLE.
REQ-019 IRDY=1 in DATA SHALL stall the transfer with no state, index or memory change.
REQ-020 A transfer with CBE=4'b1111 SHALL complete and advance the index without modifying memory.

Reset
REQ-021 An edge with RST=0 SHALL force IDLE, set TRDY, DEVSEL, STOP and AD to high-Z, and clear the index and wait counter, including mid-transaction.
REQ-022 Reset SHALL NOT clear memory contents.
REQ-023 After reset release, a transaction already in progress SHALL be ignored until FRAME=1 and IRDY=1 are sampled.

Structure
REQ-024 A shared package pci_pkg SHALL hold the command encodings and the FSM state enumeration.
REQ-025 Memory SHALL be a sub-module pci_target_mem: synchronous byte-enabled write, asynchronous read, parameter ADDR_BITS.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Single write: addr 0x1004, CBE 0111, data 0xDEADBEEF, BE 0000, FRAME high in the data phase -> DEVSEL low 1 cycle later; word 1 = 0xDEADBEEF; RELEASE, then high-Z.
- Read after write: addr 0x1004, CBE 0010, WAIT_STATES=2 -> TURN, 2 WAIT cycles, then TRDY low with AD=0xDEADBEEF.
- Byte-enable write: 0x11223344 with BE 1100 to word 1 -> word 1 = 0xDEAD3344.
- Burst to end: 4-beat write starting at word 62, FRAME held low -> words 62 and 63 written, STOP low after the 2nd beat, memory unchanged beyond 63.
- Miss and master stall: addr 0x2000 -> DEVSEL stays high-Z. Then a hit read with IRDY high for 3 cycles -> index frozen and AD stable.
- Reset mid-burst: RST low during DATA -> outputs high-Z on that edge; the next transaction decodes correctly.
